bin_pixel_packer: RTL and testbench

Sits between RAW2RGB and the SDRAM write FIFO (WR1 side) in the D5M capture path. Takes the per-pixel 12-bit channel stream and its data-valid, and thresholds each pixel to 1 bit. Packs WORD_W consecutive bits into one SDRAM word, so a 640x480 binary frame needs 19,200 16-bit writes instead of 307,200. This replaces the ad-hoc shift register and divided write clock with a single-clock valid/ready producer that also tracks line, frame and overflow status for the HPS.

---
 rtl/bin_pack_pkg.sv | 11 +
 rtl/pack_out_reg.sv | 50 +++++
 rtl/bin_pixel_packer.sv | 132 +++++++++++++
 tb/tb_bin_pixel_packer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin_pack_pkg.sv
// bin_pack_pkg: shared state type, constants and sizing helpers for bin_pixel_packer
package bin_pack_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
   localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;
   function automatic int words_per_line(input int img_w, input int word_w);
      return (img_w + word_w - 1) / word_w;
   endfunction
   function automatic int bitcnt_w(input int word_w);
      return $clog2(word_w);
   endfunction
endpackage

// File: rtl/pack_out_reg.sv
// pack_out_reg: single-entry valid/ready output register; a word arriving while a stalled word is held is dropped
module pack_out_reg
   import bin_pack_pkg::*;
#(
   parameter int WORD_W = 16
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_vld,
   input  logic [WORD_W-1:0] i_data,
   input  logic              i_ready,
   output logic [WORD_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_load,
   output logic              o_ovf,
   output logic [15:0]       o_drop_cnt
);
   logic [WORD_W-1:0] r_data;
   logic              r_valid;
   logic              r_ovf;
   logic [15:0]       r_drop_cnt;
   logic              w_free;
   logic              w_drop;
   assign w_free = !r_valid || i_ready;
   assign o_load = i_vld && w_free;
   assign w_drop = i_vld && !w_free;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (o_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
         end else if (i_ready) begin
            r_valid <= 1'b0;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != DROP_CNT_MAX) r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end
   assign o_data     = r_data;
   assign o_valid    = r_valid;
   assign o_ovf      = r_ovf;
   assign o_drop_cnt = r_drop_cnt;
endmodule

// File: rtl/bin_pixel_packer.sv
// bin_pixel_packer: thresholds pixels to 1 bit and packs WORD_W of them per word behind a valid/ready output
// Defining PACKER_ROWSUM_EN adds oROW_SUM/oROW_SUM_VLD, the count of 1-bits in each completed line
module bin_pixel_packer
   import bin_pack_pkg::*;
#(
   parameter int WORD_W = 16,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
)(
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iFVAL,
   input  logic              iDVAL,
   input  logic [11:0]       iDATA,
   input  logic [11:0]       iThreshold,
   input  logic              iREADY,
   output logic [WORD_W-1:0] oDATA,
   output logic              oVALID,
   output logic              oEOL,
   output logic              oEOF,
   output logic              oOVF,
   output logic [15:0]       oDROP_CNT,
`ifdef PACKER_ROWSUM_EN
   output logic [9:0]        oROW_SUM,
   output logic              oROW_SUM_VLD,
`endif
   output logic [15:0]       oFrame_Cont
);
   localparam int BITCNT_W = bitcnt_w(WORD_W);
   localparam int X_W      = $clog2(IMG_W);
   localparam int Y_W      = $clog2(IMG_H + 1);
   state_t              r_state, w_next;
   logic                r_fval;
   logic [X_W-1:0]      r_x;
   logic [Y_W-1:0]      r_y;
   logic [BITCNT_W-1:0] r_bit;
   logic [WORD_W-1:0]   r_shift, w_shift_nx, r_pend_data;
   logic                r_pend, r_pend_eol, r_pend_eof, r_eol, r_eof;
   logic [15:0]         r_frames;
   logic                w_bit, w_pix, w_line_end, w_done, w_flush, w_load, w_eof_evt;
   assign w_bit      = iDATA > iThreshold;
   assign w_pix      = r_state == ACTIVE && iFVAL && iDVAL && r_y != Y_W'(IMG_H);
   assign w_line_end = r_x == X_W'(IMG_W - 1);
   assign w_done     = w_line_end || r_bit == BITCNT_W'(WORD_W - 1);
   assign w_shift_nx = r_shift | (WORD_W'(w_bit) << r_bit);
   assign w_flush    = r_state == FLUSH;
   // a flush with nothing buffered still closes the frame if its last line never completed
   assign w_eof_evt  = r_pend_eof && (!r_pend || w_load);
   // sampled even in reset so a frame already running at release shows no rising edge
   always_ff @(posedge iCLK) r_fval <= iFVAL;
   always_ff @(posedge iCLK) r_state <= iRST ? IDLE : w_next;
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE && iFVAL && !r_fval) ? ACTIVE :
               (r_state == ACTIVE && !iFVAL)         ? FLUSH  :
               w_flush                               ? IDLE   : r_state;
   end
   always_ff @(posedge iCLK) begin
      if (iRST || r_state != ACTIVE) begin
         r_x     <= '0;
         r_y     <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else if (w_pix) begin
         r_x     <= w_line_end ? '0 : r_x + X_W'(1);
         r_y     <= r_y + Y_W'(w_line_end);
         r_bit   <= w_done ? '0 : r_bit + BITCNT_W'(1);
         r_shift <= w_done ? '0 : w_shift_nx;
      end
   end
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_pend      <= 1'b0;
         r_pend_data <= '0;
         r_pend_eol  <= 1'b0;
         r_pend_eof  <= 1'b0;
      end else begin
         r_pend      <= (w_pix && w_done) || (w_flush && r_bit != '0);
         r_pend_data <= w_flush ? r_shift : w_shift_nx;
         r_pend_eol  <= w_pix && w_line_end;
         r_pend_eof  <= (w_pix && w_line_end && r_y == Y_W'(IMG_H - 1)) || (w_flush && r_y != Y_W'(IMG_H));
      end
   end
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_eol    <= 1'b0;
         r_eof    <= 1'b0;
         r_frames <= '0;
      end else begin
         r_eol    <= r_pend && r_pend_eol && w_load;
         r_eof    <= w_eof_evt;
         r_frames <= r_frames + 16'(w_eof_evt);
      end
   end
   pack_out_reg #(.WORD_W(WORD_W)) u_out (
      .i_clk      (iCLK),
      .i_rst      (iRST),
      .i_vld      (r_pend),
      .i_data     (r_pend_data),
      .i_ready    (iREADY),
      .o_data     (oDATA),
      .o_valid    (oVALID),
      .o_load     (w_load),
      .o_ovf      (oOVF),
      .o_drop_cnt (oDROP_CNT)
   );
   assign oEOL        = r_eol;
   assign oEOF        = r_eof;
   assign oFrame_Cont = r_frames;
`ifdef PACKER_ROWSUM_EN
   logic [9:0] r_row_cnt, r_row_pend, r_row_sum;
   logic       r_row_vld;
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_row_cnt  <= '0;
         r_row_pend <= '0;
         r_row_sum  <= '0;
         r_row_vld  <= 1'b0;
      end else begin
         if (r_state != ACTIVE) r_row_cnt <= '0;
         else if (w_pix) begin
            r_row_cnt <= w_line_end ? '0 : r_row_cnt + 10'(w_bit);
            if (w_line_end) r_row_pend <= r_row_cnt + 10'(w_bit);
         end
         r_row_vld <= r_pend && r_pend_eol && w_load;
         if (r_pend && r_pend_eol && w_load) r_row_sum <= r_row_pend;
      end
   end
   assign oROW_SUM     = r_row_sum;
   assign oROW_SUM_VLD = r_row_vld;
`endif
endmodule

// File: tb/tb_bin_pixel_packer.sv
// tb_bin_pixel_packer: directed and random frames checked cycle by cycle against a pixel-position reference model
module tb_bin_pixel_packer;
   import bin_pack_pkg::*;
   localparam int WW = 16;
   localparam int IW = 40;
   localparam int IH = 3;
   logic          clk = 1'b0;
   logic          rst = 1'b1, fval = 1'b0, dval = 1'b0, ready = 1'b0;
   logic [11:0]   data = '0, thr = '0;
   logic [WW-1:0] o_data;
   logic          o_valid, o_eol, o_eof, o_ovf;
   logic [15:0]   o_drop, o_frames;
`ifdef PACKER_ROWSUM_EN
   logic [9:0]    o_rsum;
   logic          o_rvld;
   int            m_rcnt, p_rsum, e_rsum, e_rvld;
`endif
   int checks = 0, errors = 0;
   int m_st, m_fprev, m_x, m_y, m_word;
   int p_vld, p_data, p_eol, p_eof;
   int e_vld, e_data, e_eol, e_eof, e_ovf, e_drop, e_frames;
   int acc[$];
   int n_eol, n_eof;
   always #5 clk = ~clk;
   bin_pixel_packer #(.WORD_W(WW), .IMG_W(IW), .IMG_H(IH)) dut (
      .iCLK        (clk),
      .iRST        (rst),
      .iFVAL       (fval),
      .iDVAL       (dval),
      .iDATA       (data),
      .iThreshold  (thr),
      .iREADY      (ready),
      .oDATA       (o_data),
      .oVALID      (o_valid),
      .oEOL        (o_eol),
      .oEOF        (o_eof),
      .oOVF        (o_ovf),
      .oDROP_CNT   (o_drop),
`ifdef PACKER_ROWSUM_EN
      .oROW_SUM    (o_rsum),
      .oROW_SUM_VLD(o_rvld),
`endif
      .oFrame_Cont (o_frames)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // reference: bit position is x mod WORD_W, a word closes at a word or line boundary
   task automatic model_edge();
      int q_vld, q_data, q_eol, q_eof, pos, b, load;
      if (rst) begin
         m_st = 0; m_x = 0; m_y = 0; m_word = 0;
         p_vld = 0; p_data = 0; p_eol = 0; p_eof = 0;
         e_vld = 0; e_data = 0; e_eol = 0; e_eof = 0; e_ovf = 0; e_drop = 0; e_frames = 0;
`ifdef PACKER_ROWSUM_EN
         m_rcnt = 0; p_rsum = 0; e_rsum = 0; e_rvld = 0;
`endif
         m_fprev = fval;
         return;
      end
      load = p_vld && (!e_vld || ready);
      e_eol = load && p_eol;
      e_eof = p_eof && (!p_vld || load);
      e_frames = (e_frames + e_eof) % 65536;
      if (p_vld && !load) begin
         e_ovf = 1;
         if (e_drop < 65535) e_drop++;
      end
`ifdef PACKER_ROWSUM_EN
      e_rvld = load && p_eol;
      if (e_rvld) e_rsum = p_rsum;
`endif
      if (load) begin
         e_vld = 1;
         e_data = p_data;
      end else if (ready) e_vld = 0;
      q_vld = 0; q_data = 0; q_eol = 0; q_eof = 0;
      if (m_st == 1 && fval && dval && m_y < IH) begin
         pos = m_x % WW;
         b = (data > thr);
         m_word |= b << pos;
         q_eol = (m_x == IW - 1);
         q_eof = q_eol && m_y == IH - 1;
`ifdef PACKER_ROWSUM_EN
         m_rcnt += b;
         if (q_eol) begin
            p_rsum = m_rcnt;
            m_rcnt = 0;
         end
`endif
         if (q_eol || pos == WW - 1) begin
            q_vld = 1;
            q_data = m_word;
            m_word = 0;
         end
         if (q_eol) begin
            m_x = 0;
            m_y++;
         end else m_x++;
      end else if (m_st == 2) begin
         q_vld = (m_x % WW) != 0;
         q_data = m_word;
         q_eof = m_y < IH;
      end
      p_vld = q_vld; p_data = q_data; p_eol = q_eol; p_eof = q_eof;
      if (m_st == 0 && fval && !m_fprev) begin
         m_st = 1; m_x = 0; m_y = 0; m_word = 0;
`ifdef PACKER_ROWSUM_EN
         m_rcnt = 0;
`endif
      end else if (m_st == 1 && !fval) m_st = 2;
      else if (m_st == 2) m_st = 0;
      m_fprev = fval;
   endtask
   task automatic compare();
      check("valid", o_valid, e_vld);
      if (e_vld != 0) check("data", o_data, e_data);
      check("eol", o_eol, e_eol);
      check("eof", o_eof, e_eof);
      check("ovf", o_ovf, e_ovf);
      check("drop_cnt", o_drop, e_drop);
      check("frame_cnt", o_frames, e_frames);
`ifdef PACKER_ROWSUM_EN
      check("row_vld", o_rvld, e_rvld);
      check("row_sum", o_rsum, e_rsum);
`endif
      n_eol += o_eol;
      n_eof += o_eof;
   endtask
   task automatic cyc(input logic f, input logic d, input logic [11:0] dt, input logic r);
      fval = f; dval = d; data = dt; ready = r;
      if (o_valid && ready && !rst) acc.push_back(int'(o_data));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask
   task automatic idle(input int n, input logic f, input logic r);
      repeat (n) cyc(f, 1'b0, 12'd0, r);
   endtask
   task automatic frame_start();
      cyc(1'b0, 1'b0, 12'd0, 1'b1);
      idle(2, 1'b1, 1'b1);
   endtask
   initial begin
      int base, frames0;
      @(negedge clk);
      rst = 1'b1;
      idle(3, 1'b0, 1'b0);
      check("rst_valid", o_valid, 0);
      check("rst_drop", o_drop, 0);
      check("rst_frames", o_frames, 0);
      rst = 1'b0;
      thr = 12'd100;
      frame_start();
      base = acc.size(); n_eol = 0;
      for (int x = 0; x < IW; x++) cyc(1'b1, 1'b1, (x % 2 == 0) ? 12'd200 : 12'd50, 1'b1);
      idle(3, 1'b1, 1'b1);
      check("alt_words", acc.size() - base, words_per_line(IW, WW));
      check("alt_first", acc[base], 32'h5555);
      check("alt_last", acc[acc.size() - 1], 32'h0055);
      check("alt_eol", n_eol, 1);
      check("alt_ovf", o_ovf, 0);
      idle(4, 1'b0, 1'b1);
      thr = 12'd0;
      frame_start();
      base = acc.size(); n_eof = 0; frames0 = o_frames;
      for (int i = 0; i < IW * IH + 5; i++) cyc(1'b1, 1'b1, 12'hFFF, 1'b1);
      idle(3, 1'b1, 1'b1);
      check("full_words", acc.size() - base, IH * words_per_line(IW, WW));
      check("full_first", acc[base], 32'hFFFF);
      check("full_pad", acc[base + 2], 32'h00FF);
      check("full_eof", n_eof, 1);
      check("full_frames", o_frames, frames0 + 1);
      idle(4, 1'b0, 1'b1);
      check("full_eof_once", n_eof, 1);
      frame_start();
      base = acc.size(); n_eof = 0; frames0 = o_frames;
      repeat (5) cyc(1'b1, 1'b1, 12'hFFF, 1'b1);
      idle(5, 1'b0, 1'b1);
      check("flush_words", acc.size() - base, 1);
      check("flush_word", acc[base], 32'h001F);
      check("flush_eof", n_eof, 1);
      check("flush_frames", o_frames, frames0 + 1);
      check("flush_idle", dut.r_state, IDLE);
      frame_start();
      base = acc.size();
      for (int x = 0; x < IW; x++) cyc(1'b1, 1'b1, (x < WW) ? 12'hFFF : 12'h000, 1'b0);
      idle(3, 1'b1, 1'b0);
      check("bp_valid", o_valid, 1);
      check("bp_held", o_data, 32'hFFFF);
      check("bp_drop", o_drop, 2);
      check("bp_ovf", o_ovf, 1);
      idle(1, 1'b1, 1'b1);
      check("bp_accepted", acc.size() - base, 1);
      check("bp_acc_word", acc[base], 32'hFFFF);
      check("bp_drained", o_valid, 0);
      idle(4, 1'b0, 1'b1);
      frame_start();
      for (int x = 0; x < WW + 2; x++) cyc(1'b1, 1'b1, 12'hFFF, 1'b0);
      check("rst_mid_pre", o_valid, 1);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 12'd0, 1'b0);
      rst = 1'b0;
      check("rst_mid_valid", o_valid, 0);
      check("rst_mid_ovf", o_ovf, 0);
      check("rst_mid_drop", o_drop, 0);
      check("rst_mid_frames", o_frames, 0);
      base = acc.size();
      for (int x = 0; x < IW; x++) cyc(1'b1, 1'b1, 12'hFFF, 1'b1);
      idle(3, 1'b1, 1'b1);
      check("rst_mid_ignored", acc.size() - base, 0);
      idle(3, 1'b0, 1'b1);
      frame_start();
      repeat (WW) cyc(1'b1, 1'b1, 12'hFFF, 1'b1);
      idle(3, 1'b1, 1'b1);
      check("rst_mid_restart", acc.size() - base, 1);
      idle(4, 1'b0, 1'b1);
      for (int f = 0; f < 8; f++) begin
         thr = 12'($urandom_range(0, 4095));
         frame_start();
         repeat ($urandom_range(IW * IH / 2, IW * IH * 3 / 2))
            cyc(1'b1, 1'($urandom_range(0, 3) != 0), 12'($urandom), 1'($urandom_range(0, 3) != 0));
         idle($urandom_range(2, 6), 1'b0, 1'($urandom_range(0, 1)));
      end
      idle(5, 1'b0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
